// File: rtl/cpu1_oci_dct_unpacker.sv
// CPU1 OCI data-trace compression unpacker: turns packed 15 x 2-bit atom
// buffers into a valid/ready stream of single atoms, with a small buffer FIFO
// in front of the shifter to absorb load bursts while the sink stalls.
// Optional feature macro: CPU1_OCI_DCT_ATOM_COUNT_EN adds the atom_total port.
module cpu1_oci_dct_unpacker #(
    parameter int DEPTH     = 4,
    parameter int MAX_ATOMS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] dct_buffer,
    input  logic [3:0]  dct_count,
    input  logic        dct_load,
    input  logic        test_ending,
    input  logic        test_has_ended,
    output logic [1:0]  atom,
    output logic        atom_valid,
    input  logic        atom_ready,
    output logic        atom_last,
    output logic        overflow,
    output logic        count_err,
    output logic        drained
`ifdef CPU1_OCI_DCT_ATOM_COUNT_EN
    ,
    output logic [15:0] atom_total
`endif
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [29:0] shift_q, shift_d;
    logic [3:0]  rem_q, rem_d;
    logic [AW:0] wrPtr_q, rdPtr_q;
    logic        overflow_q, countErr_q, drained_q;

    logic [29:0] fifoBuf_q [DEPTH];
    logic [3:0]  fifoCnt_q [DEPTH];

    logic        loadSeen, loadEff, fifoEmpty, fifoFull;
    logic        handshake, lastHs, shifterFree;
    logic        pop, bypass, push, drop;
    logic [3:0]  loadCnt;

    // Decide what happens to an incoming load and whether the shifter refills
    // this cycle; a word can enter the shifter on the same edge the previous
    // word's last atom is accepted, so streams of words have no gaps.
    always_comb begin
        loadSeen    = dct_load & ~test_has_ended;
        loadEff     = loadSeen & (dct_count != 4'd0);
        loadCnt     = (dct_count > MAX_CNT) ? MAX_CNT : dct_count;
        fifoEmpty   = (wrPtr_q == rdPtr_q);
        fifoFull    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        handshake   = (state_q == SHIFT) & atom_ready;
        lastHs      = handshake & (rem_q == 4'd1);
        shifterFree = (state_q == IDLE) | lastHs;
        pop         = shifterFree & ~fifoEmpty;
        bypass      = loadEff & fifoEmpty & shifterFree;
        push        = loadEff & ~bypass & (~fifoFull | pop);
        drop        = loadEff & ~bypass & fifoFull & ~pop;
    end

    // Next shifter contents: FIFO head has priority, then a bypassing load,
    // otherwise shift out the accepted atom and fall idle after the last one.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        if (pop) begin
            state_d = SHIFT;
            shift_d = fifoBuf_q[rdPtr_q[AW-1:0]];
            rem_d   = fifoCnt_q[rdPtr_q[AW-1:0]];
        end else if (bypass) begin
            state_d = SHIFT;
            shift_d = dct_buffer;
            rem_d   = loadCnt;
        end else if (handshake) begin
            shift_d = shift_q >> 2;
            rem_d   = rem_q - 4'd1;
            if (lastHs) begin
                state_d = IDLE;
            end
        end
    end

    // Shifter FSM, FIFO pointers and sticky/status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            rem_q      <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
            countErr_q <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + (AW+1)'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + (AW+1)'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (loadSeen && (dct_count > MAX_CNT)) begin
                countErr_q <= 1'b1;
            end
            drained_q <= test_ending & fifoEmpty & (state_q == IDLE);
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoBuf_q[wrPtr_q[AW-1:0]] <= dct_buffer;
            fifoCnt_q[wrPtr_q[AW-1:0]] <= loadCnt;
        end
    end

    assign atom       = shift_q[1:0];
    assign atom_valid = (state_q == SHIFT);
    assign atom_last  = (rem_q == 4'd1);
    assign overflow   = overflow_q;
    assign count_err  = countErr_q;
    assign drained    = drained_q;

`ifdef CPU1_OCI_DCT_ATOM_COUNT_EN
    logic [15:0] atomTotal_q;

    // Running count of accepted atoms, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            atomTotal_q <= '0;
        end else if (handshake) begin
            atomTotal_q <= atomTotal_q + 16'd1;
        end
    end

    assign atom_total = atomTotal_q;
`endif

endmodule

// File: tb/tb_cpu1_oci_dct_unpacker.sv
// Self-checking bench for cpu1_oci_dct_unpacker: directed loads push expected
// atoms into a scoreboard queue, and a monitor compares every accepted atom.
module tb_cpu1_oci_dct_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_load;
    logic        test_ending;
    logic        test_has_ended;
    logic [1:0]  atom;
    logic        atom_valid;
    logic        atom_ready;
    logic        atom_last;
    logic        overflow;
    logic        count_err;
    logic        drained;
`ifdef CPU1_OCI_DCT_ATOM_COUNT_EN
    logic [15:0] atom_total;
`endif

    int checks   = 0;
    int failures = 0;
    int tbTotal  = 0;
    logic [2:0] sbQ[$];

    cpu1_oci_dct_unpacker #(.DEPTH(4), .MAX_ATOMS(15)) dut (
        .clk(clk),
        .reset(reset),
        .dct_buffer(dct_buffer),
        .dct_count(dct_count),
        .dct_load(dct_load),
        .test_ending(test_ending),
        .test_has_ended(test_has_ended),
        .atom(atom),
        .atom_valid(atom_valid),
        .atom_ready(atom_ready),
        .atom_last(atom_last),
        .overflow(overflow),
        .count_err(count_err),
        .drained(drained)
`ifdef CPU1_OCI_DCT_ATOM_COUNT_EN
        ,
        .atom_total(atom_total)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one load strobe; queue its atoms when the unpacker should keep it.
    task automatic applyStimulus(input logic [29:0] b, input logic [3:0] c, input bit expectAccept);
        dct_buffer = b;
        dct_count  = c;
        dct_load   = 1'b1;
        if (expectAccept) begin
            for (int i = 0; i < int'(c); i++) begin
                sbQ.push_back({b[2*i +: 2], (i == int'(c) - 1)});
            end
        end
        @(posedge clk);
        #1;
        dct_load = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbQ.delete();
        tbTotal = 0;
    endtask

    task automatic waitDrain(input string name, input int bound);
        int n = 0;
        while (sbQ.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, sbQ.size(), 0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted atom must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && atom_valid && atom_ready) begin
            tbTotal++;
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_atom actual=%0d expected=none at %0t", atom, $time);
            end else begin
                logic [2:0] exp;
                exp = sbQ.pop_front();
                checkOutput("atom", {30'd0, atom}, {30'd0, exp[2:1]});
                checkOutput("atom_last", {31'd0, atom_last}, {31'd0, exp[0]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset          = 1'b1;
        dct_buffer     = '0;
        dct_count      = '0;
        dct_load       = 1'b0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        atom_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_atom", {30'd0, atom}, 32'd0);
        checkOutput("rst_valid", {31'd0, atom_valid}, 32'd0);
        checkOutput("rst_last", {31'd0, atom_last}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_count_err", {31'd0, count_err}, 32'd0);
        checkOutput("rst_drained", {31'd0, drained}, 32'd0);

        // Test 1: single word, atoms 3,2,1,0, bypass latency of one cycle.
        $display("[TB] test 1: single word bypass");
        atom_ready = 1'b1;
        applyStimulus(30'h1B, 4'd4, 1'b1);
        checkOutput("t1_valid_latency", {31'd0, atom_valid}, 32'd1);
        checkOutput("t1_first_atom", {30'd0, atom}, 32'd3);
        waitDrain("t1_drain", 20);
        checkOutput("t1_idle", {31'd0, atom_valid}, 32'd0);
`ifdef CPU1_OCI_DCT_ATOM_COUNT_EN
        checkOutput("t1_atom_total", {16'd0, atom_total}, 32'd4);
`endif

        // Test 2: fill shifter and FIFO under back-pressure, then overflow.
        $display("[TB] test 2: fill, overflow, bubble-free drain");
        atom_ready = 1'b0;
        applyStimulus(30'h3FFF_FFFF, 4'd15, 1'b1);
        checkOutput("t2_valid_stalled", {31'd0, atom_valid}, 32'd1);
        applyStimulus(30'h1234_5678, 4'd15, 1'b1);
        applyStimulus(30'h0000_02C6, 4'd5, 1'b1);
        applyStimulus(30'h0000_0039, 4'd3, 1'b1);
        applyStimulus(30'h0000_000E, 4'd2, 1'b1);
        checkOutput("t2_no_overflow_yet", {31'd0, overflow}, 32'd0);
        applyStimulus(30'h0000_00FF, 4'd4, 1'b0);
        checkOutput("t2_overflow", {31'd0, overflow}, 32'd1);
        begin
            int cycles = 0;
            atom_ready = 1'b1;
            while (sbQ.size() != 0 && cycles < 200) begin
                @(posedge clk);
                cycles++;
            end
            #1;
            checkOutput("t2_drain_cycles", cycles, 40);
        end
        idleCycles(3);
        checkOutput("t2_idle", {31'd0, atom_valid}, 32'd0);

        // Test 3: zero count discarded, partial and full words, no count error.
        $display("[TB] test 3: count boundaries");
        applyStimulus(30'h2AAA_AAAA, 4'd0, 1'b0);
        idleCycles(2);
        checkOutput("t3_count0_nothing", {31'd0, atom_valid}, 32'd0);
        applyStimulus(30'h0ABC_DEF1, 4'd12, 1'b1);
        waitDrain("t3_drain12", 40);
        applyStimulus(30'h2468_ACE0, 4'd15, 1'b1);
        waitDrain("t3_drain15", 40);
        applyStimulus(30'h1357_9BDF, 4'd14, 1'b1);
        waitDrain("t3_drain14", 40);
        checkOutput("t3_count_err", {31'd0, count_err}, 32'd0);

        // Test 4: drained after the last pending atom; loads ignored after end.
        $display("[TB] test 4: drain and test_has_ended");
        doReset();
        atom_ready = 1'b0;
        applyStimulus(30'h0000_0027, 4'd3, 1'b1);
        applyStimulus(30'h0000_0009, 4'd2, 1'b1);
        test_ending = 1'b1;
        idleCycles(2);
        checkOutput("t4_not_drained", {31'd0, drained}, 32'd0);
        atom_ready = 1'b1;
        waitDrain("t4_drain", 20);
        checkOutput("t4_drained_lag", {31'd0, drained}, 32'd0);
        idleCycles(1);
        checkOutput("t4_drained", {31'd0, drained}, 32'd1);
        atom_ready = 1'b0;
        applyStimulus(30'h0000_0111, 4'd6, 1'b1);
        applyStimulus(30'h0000_0222, 4'd6, 1'b1);
        applyStimulus(30'h0000_0333, 4'd6, 1'b1);
        applyStimulus(30'h0000_0444, 4'd6, 1'b1);
        applyStimulus(30'h0000_0555, 4'd6, 1'b1);
        test_has_ended = 1'b1;
        applyStimulus(30'h0000_0666, 4'd5, 1'b0);
        idleCycles(2);
        checkOutput("t4_ended_no_overflow", {31'd0, overflow}, 32'd0);
        test_has_ended = 1'b0;
        atom_ready = 1'b1;
        waitDrain("t4_drain_full", 60);
        idleCycles(3);
        checkOutput("t4_no_extra_atoms", {31'd0, atom_valid}, 32'd0);
        test_ending = 1'b0;

        // Test 5: reset in the middle of a word with rem=7 drops everything.
        $display("[TB] test 5: reset mid-shift");
        atom_ready = 1'b0;
        applyStimulus(30'h2DB6_DB6D, 4'd15, 1'b1);
        applyStimulus(30'h0000_00AA, 4'd4, 1'b1);
        applyStimulus(30'h0000_00BB, 4'd4, 1'b1);
        applyStimulus(30'h0000_00CC, 4'd4, 1'b1);
        applyStimulus(30'h0000_00DD, 4'd4, 1'b1);
        applyStimulus(30'h0000_00EE, 4'd4, 1'b0);
        checkOutput("t5_overflow_set", {31'd0, overflow}, 32'd1);
        atom_ready = 1'b1;
        idleCycles(8);
        atom_ready = 1'b0;
        checkOutput("t5_pending_atoms", sbQ.size(), 7 + 16);
        doReset();
        checkOutput("t5_valid_cleared", {31'd0, atom_valid}, 32'd0);
        checkOutput("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
        atom_ready = 1'b1;
        idleCycles(6);
        checkOutput("t5_fifo_empty", {31'd0, atom_valid}, 32'd0);
`ifdef CPU1_OCI_DCT_ATOM_COUNT_EN
        checkOutput("t5_atom_total", {16'd0, atom_total}, tbTotal);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
